// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one read-only BRAM among N_REQ burst loaders.
// One whole burst is owned at a time; returned data is tagged with its owner.
module bram_read_arbiter #(
  parameter int N_REQ      = 3,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int LEN_WIDTH  = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [N_REQ-1:0]            gnt,
  output logic                        busy,
  output logic                        bram_en,
  output logic                        bram_ren,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  input  logic [W-1:0]                bram_dout,
  output logic                        rd_valid,
  output logic [W-1:0]                rd_data,
  output logic [N_REQ-1:0]            rd_owner,
  output logic [N_REQ-1:0]            burst_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]        done_q, done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    en_q, en_d;
  logic                    ren_q, ren_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        own_q, own_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [N_REQ-1:0]        own_sr_q [RD_LATENCY];

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [ADDR_WIDTH-1:0]   pick_base;
  logic [LEN_WIDTH-1:0]    pick_len;

  // Search upward from the requester after the last one served.
  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    jj         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + 1 + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDX_W'(j);
      if (!pick_found && req[jj]) begin
        pick_found = 1'b1;
        pick_idx   = jj;
      end
    end
  end

  assign pick_base = req_base[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_len  = req_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];

  // Next contents of the valid pipeline; DRAIN ends once it would be empty.
  assign vld_d = RD_LATENCY'({vld_q, ren_q});

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    en_d    = en_q;
    ren_d   = ren_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d = N_REQ'(1) << pick_idx;
          own_d = pick_idx;
          en_d  = 1'b1;
          if (pick_len != '0) begin
            state_d = ISSUE;
            addr_d  = pick_base;
            ren_d   = 1'b1;
            cnt_d   = pick_len;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == LEN_WIDTH'(1)) begin
          ren_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (vld_d == '0) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          en_d    = 1'b0;
          ptr_d   = own_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      ren_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      own_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) own_sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      ren_q   <= ren_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      vld_q   <= vld_d;
      own_sr_q[0] <= gnt_q;
      for (int i = 1; i < RD_LATENCY; i++) own_sr_q[i] <= own_sr_q[i-1];
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);
  assign bram_en    = en_q;
  assign bram_ren   = ren_q;
  assign bram_addr  = addr_q;
  assign rd_valid   = vld_q[RD_LATENCY-1];
  assign rd_data    = bram_dout;
  assign rd_owner   = vld_q[RD_LATENCY-1] ? own_sr_q[RD_LATENCY-1] : '0;
  assign burst_done = done_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Scoreboard bench for bram_read_arbiter: directed bursts queue expected beats
// and completions; a negedge monitor pops and compares what the DUT presents.
module tb_bram_read_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int AW = 18;
  localparam int LW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_base = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    gnt;
  logic            busy, bram_en, bram_ren, rd_valid;
  logic [AW-1:0]   bram_addr;
  logic [W-1:0]    bram_dout, rd_data, mem_p1;
  logic [N-1:0]    rd_owner, burst_done;

  typedef struct packed { logic [W-1:0] data; logic [N-1:0] own; } beat_t;
  beat_t        beat_q[$];
  logic [N-1:0] done_q[$];

  int checks = 0;
  int errors = 0;

  bram_read_arbiter #(.N_REQ(N), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
    .gnt(gnt), .busy(busy), .bram_en(bram_en), .bram_ren(bram_ren),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_owner(rd_owner), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] memf(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'h29, a[17:16]};
  endfunction

  // Two-cycle BRAM: address registered, then output registered.
  always @(posedge clk) begin
    mem_p1    <= memf(bram_addr);
    bram_dout <= mem_p1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] base, input logic [LW-1:0] len);
    req_base[idx*AW +: AW] = base;
    req_len[idx*LW +: LW]  = len;
  endtask

  task automatic push_burst(input int idx, input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    beat_t b;
    for (int i = 0; i < len; i++) begin
      a      = base + AW'(i);
      b.data = memf(a);
      b.own  = N'(1) << idx;
      beat_q.push_back(b);
    end
    done_q.push_back(N'(1) << idx);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", busy, 0);
    check("idle_gnt", gnt, 0);
  endtask

  // Monitor: every presented beat or completion pops the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = beat_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_owner", rd_owner, e.own);
        end
      end else if (rd_owner != '0) check("owner_idle", rd_owner, 0);
      if (burst_done != '0) begin
        if (done_q.size() == 0) check("unexpected_done", burst_done, 0);
        else check("burst_done", burst_done, done_q.pop_front());
      end
    end
  end

  initial begin
    logic [N-1:0] order [4];
    logic [N-1:0] prev;
    logic [AW-1:0] exp_a;
    int ng, gap, gap_bad, oh_bad;

    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_en", bram_en, 0);
    check("rst_ren", bram_ren, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_owner", rd_owner, 0);
    check("rst_done", burst_done, 0);
    rst = 1'b0;

    // Single burst
    set_req(0, 18'd147584, 18'd4);
    push_burst(0, 18'd147584, 4);
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      check("single_gnt", gnt, 3'b001);
      check("single_ren", bram_ren, 1);
      check("single_addr", bram_addr, 147584 + i);
      @(negedge clk);
    end
    check("single_ren_off", bram_ren, 0);
    wait_idle(50);

    // Round-robin from reset priority
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 18'd100, 18'd2);
    set_req(1, 18'd200, 18'd2);
    set_req(2, 18'd300, 18'd2);
    push_burst(0, 18'd100, 2);
    push_burst(1, 18'd200, 2);
    push_burst(2, 18'd300, 2);
    push_burst(0, 18'd100, 2);
    req = 3'b111;
    ng = 0; gap = 0; gap_bad = 0; oh_bad = 0; prev = '0;
    for (int i = 0; i < 4; i++) order[i] = '0;
    for (int c = 0; c < 300 && ng < 4; c++) begin
      @(negedge clk);
      if (!$onehot0(gnt)) oh_bad++;
      if (gnt != '0 && prev == '0) begin
        if (ng > 0 && gap != 1) gap_bad++;
        order[ng] = gnt;
        ng++;
        gap = 0;
      end else if (gnt == '0) gap++;
      prev = gnt;
    end
    req = 3'b000;
    check("rr_count", ng, 4);
    check("rr_order0", order[0], 3'b001);
    check("rr_order1", order[1], 3'b010);
    check("rr_order2", order[2], 3'b100);
    check("rr_order3", order[3], 3'b001);
    check("rr_gap", gap_bad, 0);
    check("rr_onehot", oh_bad, 0);
    wait_idle(50);

    // Zero-length burst
    @(negedge clk);
    set_req(1, 18'd555, 18'd0);
    done_q.push_back(3'b010);
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    check("zero_gnt", gnt, 3'b010);
    check("zero_ren", bram_ren, 0);
    check("zero_busy", busy, 1);
    @(negedge clk);
    check("zero_gnt_clr", gnt, 0);
    check("zero_ren2", bram_ren, 0);
    check("zero_busy_clr", busy, 0);

    // Address wrap
    @(negedge clk);
    set_req(2, 18'd262142, 18'd4);
    push_burst(2, 18'd262142, 4);
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    check("wrap_gnt", gnt, 3'b100);
    exp_a = 18'd262142;
    for (int i = 0; i < 4; i++) begin
      check("wrap_addr", bram_addr, exp_a);
      exp_a = exp_a + 18'd1;
      @(negedge clk);
    end
    wait_idle(50);

    // Reset during the third ISSUE cycle of a len=8 burst
    @(negedge clk);
    set_req(0, 18'd5000, 18'd8);
    req = 3'b001;
    @(negedge clk);
    check("mid_gnt", gnt, 3'b001);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = 3'b000;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_en", bram_en, 0);
    check("mid_rst_ren", bram_ren, 0);
    check("mid_rst_addr", bram_addr, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_owner", rd_owner, 0);
    check("mid_rst_done", burst_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_req(2, 18'd700, 18'd2);
    push_burst(2, 18'd700, 2);
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    check("post_rst_gnt", gnt, 3'b100);
    wait_idle(50);

    // Request dropped mid-burst
    @(negedge clk);
    set_req(0, 18'd9000, 18'd6);
    push_burst(0, 18'd9000, 6);
    req = 3'b001;
    @(negedge clk);
    check("drop_gnt", gnt, 3'b001);
    @(negedge clk);
    req = 3'b000;
    wait_idle(100);

    repeat (3) @(negedge clk);
    check("beats_left", beat_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
Name: bram_read_arbiter

Overview:
- Shares the single read-only weight/bias BRAM among N_REQ loaders (e.g. layer-1 weight loader, layer-2 weight loader, bias loader).
- Each requester asks for one burst (base address, length). The arbiter grants requesters round-robin, one whole burst at a time.
- It drives the BRAM port, returns read data tagged with the owning requester, and pulses a per-requester completion flag.

Parameters:
- N_REQ, 3, number of requesters.
- W, 8, BRAM data width.
- ADDR_WIDTH, 18, BRAM address width.
- LEN_WIDTH, 18, burst length width.
- RD_LATENCY, 2, cycles from address edge to valid bram_dout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester burst request (level).
- req_base  in  N_REQ*ADDR_WIDTH  per-requester start address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len  in  N_REQ*LEN_WIDTH  per-requester word count; slice i likewise.
- gnt  out  N_REQ  one-hot grant, held for the whole burst.
- busy  out  1  high while state != IDLE.
- bram_en  out  1  BRAM enable.
- bram_ren  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_dout  in  W  BRAM read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  W  combinational pass-through of bram_dout.
- rd_owner  out  N_REQ  one-hot owner of rd_data; 0 when rd_valid=0.
- burst_done  out  N_REQ  one-cycle pulse on the owner's bit at burst completion.

Behaviour:
- Reset values (asynchronous): gnt=0, busy=0, bram_en=0, bram_ren=0, bram_addr=0, rd_valid=0, rd_owner=0, burst_done=0, state=IDLE. The round-robin pointer is reset so requester 0 has highest priority.
- States:
  - IDLE: at each edge with any req bit set, pick the first set bit, searching from (last_grant+1) mod N_REQ upward.
    - Register gnt to that one-hot and latch base/len.
    - If len>0: go to ISSUE, with bram_addr<=base and bram_en=bram_ren<=1.
    - If len==0: go to DRAIN with no reads issued.
  - ISSUE: one address per cycle. bram_addr increments by 1 each edge, modulo 2^ADDR_WIDTH (wraps to 0). After len addresses have been presented, bram_ren<=0 and the state goes to DRAIN.
  - DRAIN: wait until the read pipeline is empty. At the edge after the last rd_valid cycle (immediately for len==0): pulse burst_done[owner], clear gnt, set bram_en<=0, update last_grant, and return to IDLE.
- Read latency: rd_valid is bram_ren delayed by RD_LATENCY cycles through a shift register. rd_owner is gnt delayed by the same amount, masked by rd_valid. Exactly len rd_valid cycles occur per burst, in address order, with no gaps.
- Example: grant edge E0 puts address base on the port after E0. Data for base has rd_valid=1 in the cycle after edge E0+RD_LATENCY.
- The burst_done cycle is in IDLE, so arbitration can happen at the edge ending that cycle. Minimum idle gap between bursts is therefore 1 cycle.
- req, req_base and req_len are sampled only at the grant edge. Requesters hold req until gnt. Dropping req mid-burst does not abort the burst. A requester still asserting req after burst_done is eligible again, but only after the other pending requesters have been served.
- Only one burst is in flight at a time; no preemption.
- Reset mid-burst: everything clears asynchronously, in-flight data is discarded (no rd_valid, no burst_done), and the pointer returns to its reset value.
- bram_en stays high from grant until DRAIN exits, so the read pipeline keeps advancing.

Test Plan:
- Single burst: req=3'b001, base=147584, len=4.
  - gnt=001 from edge 1; bram_addr=147584..147587 on consecutive cycles.
  - rd_valid for 4 cycles with rd_data=mem[147584..147587] and rd_owner=001.
  - burst_done[0] pulses once, then gnt=0 and busy=0.
- Round-robin: req=3'b111 held for 4 bursts of len 2 each.
  - Grant order is 0,1,2,0.
  - Never two gnt bits set; 1-cycle gap between bursts.
- Zero length: req=3'b010, len=0.
  - gnt=010 for one cycle, bram_ren never asserts, zero rd_valid cycles.
  - burst_done[1] pulses, back to IDLE.
- Address wrap: base=262142, len=4.
  - bram_addr sequence is 262142, 262143, 0, 1; 4 rd_valid cycles.
- Reset mid-burst: assert rst during the 3rd ISSUE cycle of a len=8 burst.
  - All outputs go 0 immediately; no burst_done is emitted.
  - After release, req=3'b100 is granted with the pointer at reset priority.
- Request drop: req[0] deasserted during ISSUE of a len=6 burst.
  - All 6 words are still delivered and burst_done[0] pulses.
